// File: rtl/lx32_fetch_unit.sv
// LX32 fetch stage: PC, one outstanding imem request, single-entry registered buffer toward decode.
// if_* valid one cycle after the imem response; no request is issued while decode stalls a full buffer.
module lx32_fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_pc,
    output logic [31:0]      if_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_pc_q;
    logic [WIDTH-1:0] redirect_tgt;
    logic             can_issue;
    logic             req_fire;
    logic             rsp_keep;
    logic             unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The buffer is always empty by the time a response lands, because a
    // request only goes out when the buffer is empty or draining this cycle.
    assign can_issue      = !if_valid || if_ready;
    assign imem_req_valid = (state_q == S_REQ) && can_issue && !redirect_valid && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            state_q <= state_d;

            if (redirect_valid) begin
                pc_q <= redirect_tgt;
            end else if (req_fire) begin
                pc_q <= pc_q + WIDTH'(4);
            end

            if (req_fire) begin
                req_pc_q <= pc_q;
            end

            // A redirect squashes the buffer even if decode takes it this cycle.
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (rsp_keep) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc_q;
                if_instr <= imem_rsp_data;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lx32_fetch_unit.sv
// Bench for lx32_fetch_unit: transaction-level model plus memory with variable latency.
module tb_lx32_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    lx32_fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: next fetch address, decode-facing buffer, and the one outstanding
    // memory transaction (which doubles as the memory's own pending request).
    logic [31:0] m_pc       = RESET_PC;
    logic        m_if_valid = 1'b0;
    logic [31:0] m_if_pc    = '0;
    logic [31:0] m_if_instr = '0;
    logic        mem_busy   = 1'b0;
    logic        mem_squash = 1'b0;
    logic [31:0] mem_addr   = '0;
    int          mem_cnt    = 0;
    int          lat_mode   = 1;

    logic [31:0] req_q[$];
    int          req_cyc_q[$];
    logic [31:0] acc_q[$];
    int          cyc           = 0;
    int          first_vld_cyc = -1;
    int          rel_cyc       = -1;
    logic        was_rst       = 1'b0;
    logic        exp_req;
    logic        accept;
    logic        deliver;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory response driver: answers the pending request when its latency expires.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = mem_busy && (mem_cnt == 0) && !rst;
            imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
        end
    end

    // Compare process: check every cycle, then advance the model across the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            exp_req = !rst && !redirect_valid && !mem_busy && (!m_if_valid || if_ready);
            check("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req) check("req_addr", imem_req_addr, m_pc);
            check("if_valid", 32'(if_valid), 32'(m_if_valid));
            if (m_if_valid) begin
                check("if_pc", if_pc, m_if_pc);
                check("if_instr", if_instr, m_if_instr);
            end

            if (rst) begin
                m_pc          = RESET_PC;
                m_if_valid    = 1'b0;
                m_if_pc       = '0;
                m_if_instr    = '0;
                mem_busy      = 1'b0;
                mem_squash    = 1'b0;
                first_vld_cyc = -1;
                was_rst       = 1'b1;
            end else begin
                if (was_rst) begin
                    rel_cyc = cyc;
                    was_rst = 1'b0;
                end
                if (if_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (imem_req_valid && imem_req_ready) begin
                    req_q.push_back(imem_req_addr);
                    req_cyc_q.push_back(cyc);
                end
                if (if_valid && if_ready) acc_q.push_back(if_pc);

                accept  = exp_req && imem_req_ready;
                deliver = imem_rsp_valid && !mem_squash && !redirect_valid;

                if (redirect_valid) m_if_valid = 1'b0;
                else if (deliver) begin
                    m_if_valid = 1'b1;
                    m_if_pc    = mem_addr;
                    m_if_instr = mem_word(mem_addr);
                end else if (m_if_valid && if_ready) m_if_valid = 1'b0;

                if (imem_rsp_valid) mem_busy = 1'b0;
                else if (mem_busy) begin
                    mem_cnt--;
                    if (redirect_valid) mem_squash = 1'b1;
                end
                if (accept) begin
                    mem_busy   = 1'b1;
                    mem_squash = 1'b0;
                    mem_addr   = m_pc;
                    mem_cnt    = (lat_mode > 0 ? lat_mode : int'($urandom_range(1, 4))) - 1;
                end

                if (redirect_valid) m_pc = redirect_pc & ~32'h3;
                else if (accept) m_pc = m_pc + 32'd4;
            end
            cyc++;
        end
    end

    // One reset cycle, then reset values and the first request at RESET_PC.
    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        req_q.delete();
        req_cyc_q.delete();
        acc_q.delete();
        #3;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_first_req", 32'(imem_req_valid), 32'd1);
        check("rst_first_addr", imem_req_addr, RESET_PC);
    endtask

    initial begin
        int n;
        int base;
        int abase;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;

        // Reset and streaming at k=1.
        lat_mode = 1;
        do_reset();
        repeat (10) @(negedge clk);
        check("p1_nreq", 32'(req_q.size() >= 3), 32'd1);
        check("p1_nacc", 32'(acc_q.size() >= 3), 32'd1);
        if (req_q.size() >= 3 && acc_q.size() >= 3) begin
            check("p1_req0", req_q[0], 32'h0);
            check("p1_req1", req_q[1], 32'h4);
            check("p1_req2", req_q[2], 32'h8);
            check("p1_req_gap1", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd2);
            check("p1_req_gap2", 32'(req_cyc_q[2] - req_cyc_q[1]), 32'd2);
            check("p1_req_first_cyc", 32'(req_cyc_q[0] - rel_cyc), 32'd0);
            check("p1_acc0", acc_q[0], 32'h0);
            check("p1_acc1", acc_q[1], 32'h4);
            check("p1_acc2", acc_q[2], 32'h8);
        end
        // Request in the first cycle out of reset, response next, buffer valid after that.
        check("p1_first_vld", 32'(first_vld_cyc - rel_cyc), 32'd2);

        // Decode stall on the first instruction.
        if_ready = 1'b0;
        do_reset();
        n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("p2_vld_seen", 32'(if_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #3;
            end
            check("p2_stall_vld", 32'(if_valid), 32'd1);
            check("p2_stall_pc", if_pc, 32'h0);
            check("p2_stall_instr", if_instr, mem_word(32'h0));
            check("p2_stall_noreq", 32'(imem_req_valid), 32'd0);
        end
        @(negedge clk);
        if_ready = 1'b1;
        #3;
        check("p2_resume_req", 32'(imem_req_valid), 32'd1);
        check("p2_resume_addr", imem_req_addr, 32'h4);

        // Redirect while 0x8 is outstanding (k=3).
        lat_mode = 3;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_busy && mem_addr == 32'h8 && mem_cnt > 0) && n < 60);
        check("p3_reach_wait", 32'(mem_busy && mem_addr == 32'h8), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        base           = req_q.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        abase          = acc_q.size();
        repeat (14) @(negedge clk);
        check("p3_nreq", 32'(req_q.size() > base), 32'd1);
        check("p3_nacc", 32'(acc_q.size() > abase), 32'd1);
        if (req_q.size() > base) check("p3_req", req_q[base], 32'h100);
        if (acc_q.size() > abase) check("p3_acc", acc_q[abase], 32'h100);

        // Redirect coincident with the response for 0x4.
        lat_mode = 2;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_busy && mem_addr == 32'h4 && mem_cnt == 0) && n < 60);
        check("p4_reach_rsp", 32'(mem_busy && mem_addr == 32'h4), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("p4_no_vld", 32'(if_valid), 32'd0);
        check("p4_req", 32'(imem_req_valid), 32'd1);
        check("p4_addr", imem_req_addr, 32'h200);

        // Back-to-back redirects while draining, misaligned target.
        lat_mode = 4;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_busy && mem_addr == 32'h4 && mem_cnt >= 2) && n < 60);
        check("p5_reach_wait", 32'(mem_busy && mem_addr == 32'h4), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        base           = req_q.size();
        @(negedge clk);
        redirect_pc = 32'h402;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("p5_nreq", 32'(req_q.size() > base), 32'd1);
        if (req_q.size() > base) check("p5_req", req_q[base], 32'h400);

        // Address wrap.
        lat_mode = 1;
        do_reset();
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        base           = req_q.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        abase          = acc_q.size();
        repeat (12) @(negedge clk);
        check("p6_nreq", 32'(req_q.size() > base + 1), 32'd1);
        check("p6_nacc", 32'(acc_q.size() > abase + 1), 32'd1);
        if (req_q.size() > base + 1) begin
            check("p6_req_top", req_q[base], 32'hFFFF_FFFC);
            check("p6_req_wrap", req_q[base+1], 32'h0);
        end
        if (acc_q.size() > abase + 1) begin
            check("p6_acc_top", acc_q[abase], 32'hFFFF_FFFC);
            check("p6_acc_wrap", acc_q[abase+1], 32'h0);
        end

        // Reset while a request is outstanding.
        lat_mode = 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_busy && mem_cnt > 0) && n < 30);
        check("p7_reach_wait", 32'(mem_busy), 32'd1);
        do_reset();
        repeat (8) @(negedge clk);
        check("p7_nreq", 32'(req_q.size() >= 2), 32'd1);
        if (req_q.size() >= 2) begin
            check("p7_req0", req_q[0], RESET_PC);
            check("p7_req1", req_q[1], RESET_PC + 32'd4);
        end

        // Randomized traffic; the compare process carries the checking.
        lat_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if_ready       = ($urandom_range(0, 9) < 7);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            rst            = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
